util_heartbeat_gen: RTL

Periodic keep-alive (heartbeat) generator; the transmitting end of the watchdog link. Emits a pulse on `beat` every `period` ticks of `cnt_pulse`, high for `width` ticks, and drives the `monitor_in` of a `util_watch_dog` on the far side. Adds an immediate-beat request (`kick`) and beat suppression (`suppress`) for fault injection, plus saturating beat and skip counters for status registers.

---
 rtl/util_heartbeat_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/util_heartbeat_gen.sv
// Heartbeat generator: periodic keep-alive pulse with kick, suppress and
// saturating beat/skip status counters. Drives the watchdog monitor input.
module util_heartbeat_gen (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [31:0] period,
  input  logic [31:0] width,
  input  logic        cnt_pulse,
  input  logic        kick,
  input  logic        suppress,
  output logic        beat,
  output logic        beat_start,
  output logic [31:0] beat_cnt,
  output logic [31:0] skip_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] t;
  logic [31:0] t_nxt;
  logic [31:0] period_q;
  logic [31:0] width_q;
  logic [31:0] period_eff;
  logic [31:0] width_eff;
  logic [32:0] t_inc;
  logic        period_hit;
  logic        width_hit;
  logic        start;
  logic        clear;
  logic        beat_nxt;
  logic        beat_start_nxt;
  logic        beat_cnt_inc;
  logic        skip_cnt_inc;

  assign clear = ~rstn | ~en;

  // Effective configuration, only captured into period_q/width_q on a start.
  always_comb begin
    period_eff = period;
    width_eff  = width;
    if (period < 32'd2) begin
      period_eff = 32'd2;
    end
    if (width == 32'd0) begin
      width_eff = 32'd1;
    end else if (width >= period_eff) begin
      width_eff = period_eff - 32'd1;
    end
  end

  // 33-bit increment keeps the period/width match free of wrap effects.
  assign t_inc      = {1'b0, t} + 33'd1;
  assign period_hit = cnt_pulse && (t_inc == {1'b0, period_q});
  assign width_hit  = t_inc == {1'b0, width_q};

  always_comb begin
    state_nxt      = state;
    t_nxt          = t;
    start          = 1'b0;
    beat_nxt       = 1'b0;
    beat_start_nxt = 1'b0;
    beat_cnt_inc   = 1'b0;
    skip_cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        start = 1'b1;
      end
      S_HIGH, S_LOW: begin
        start = kick | period_hit;
      end
      default: begin
        start = 1'b1;
      end
    endcase
    if (start) begin
      state_nxt = S_HIGH;
      t_nxt     = 32'd0;
    end else if (cnt_pulse) begin
      t_nxt = t_inc[31:0];
      if ((state == S_HIGH) && width_hit) begin
        state_nxt = S_LOW;
      end
    end
    // Suppress masks the level only; the phase keeps running underneath.
    beat_nxt       = (state_nxt == S_HIGH) && !suppress;
    beat_start_nxt = start && !suppress;
    beat_cnt_inc   = start && !suppress && (beat_cnt != 32'hFFFF_FFFF);
    skip_cnt_inc   = start && suppress && (skip_cnt != 32'hFFFF_FFFF);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= S_IDLE;
      t          <= 32'd0;
      period_q   <= 32'd2;
      width_q    <= 32'd1;
      beat       <= 1'b0;
      beat_start <= 1'b0;
      beat_cnt   <= 32'd0;
      skip_cnt   <= 32'd0;
    end else begin
      state      <= state_nxt;
      t          <= t_nxt;
      beat       <= beat_nxt;
      beat_start <= beat_start_nxt;
      if (start) begin
        period_q <= period_eff;
        width_q  <= width_eff;
      end
      if (beat_cnt_inc) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
      if (skip_cnt_inc) begin
        skip_cnt <= skip_cnt + 32'd1;
      end
    end
  end

endmodule
